victory_tracker: RTL

- Parametrised successor to the two-player round-win detector.
- Supports NUM_PLAYERS contestants. A round is won when exactly one player presses while that player's edge light is lit.
- Emits a one-cycle winner/gameReset pulse per round and keeps a per-player round score.
- Declares a match winner when a score reaches MATCH_POINTS, then holds until a new match is requested.
- Sits between the playfield light chain, which supplies edgeLight, and the score displays / round restart logic.

---
 rtl/victory_tracker.sv | 136 +++++++++++++
 1 files changed

// File: rtl/victory_tracker.sv
// victory_tracker: multi-player round/match win detector.
//
// A round is won when exactly one player presses while that player's edge
// light is lit. The winner gets a one-cycle winner/gameReset pulse and a
// point. The first player to reach MATCH_POINTS is held as match winner
// until newMatch is requested.
//
// Ports:
//   clk          system clock, rising edge
//   Reset        asynchronous, active-high reset
//   press        player button levels (already synchronised), bit i = player i
//   edgeLight    bit i high when the light sits at player i's goal
//   newMatch     clear all scores and start a new match (highest priority)
//   winner       one-hot round winner, one cycle per round
//   gameReset    high together with any winner bit
//   score        packed scores, player i at [i*SCORE_W +: SCORE_W]
//   matchOver    high while a match winner is held
//   matchWinner  one-hot match winner while matchOver, zero otherwise
//
// Optional build macro:
//   VICTORY_EDGE_EN  qualify on rising edges of press instead of levels, so
//                    a held button wins at most one round.
module victory_tracker #(
    parameter int NUM_PLAYERS  = 2,
    parameter int SCORE_W      = 3,
    parameter int MATCH_POINTS = 7
) (
    input  logic                           clk,
    input  logic                           Reset,
    input  logic [NUM_PLAYERS-1:0]         press,
    input  logic [NUM_PLAYERS-1:0]         edgeLight,
    input  logic                           newMatch,
    output logic [NUM_PLAYERS-1:0]         winner,
    output logic                           gameReset,
    output logic [NUM_PLAYERS*SCORE_W-1:0] score,
    output logic                           matchOver,
    output logic [NUM_PLAYERS-1:0]         matchWinner
);

    localparam int IDX_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WIN        = 2'd1,
        MATCH_OVER = 2'd2
    } state_t;

    state_t                         state_q, state_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [NUM_PLAYERS*SCORE_W-1:0] score_q, score_d;

    logic [NUM_PLAYERS-1:0] press_qual;
    logic [NUM_PLAYERS-1:0] hit;
    logic                   one_hot;
    logic                   qualify;
    logic [IDX_W-1:0]       qual_idx;
    logic [SCORE_W-1:0]     score_inc;

`ifdef VICTORY_EDGE_EN
    logic [NUM_PLAYERS-1:0] press_prev_q, press_prev_d;

    always_comb begin
        press_prev_d = newMatch ? '0 : press;
        press_qual   = press & ~press_prev_q;
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) press_prev_q <= '0;
        else       press_prev_q <= press_prev_d;
    end
`else
    always_comb press_qual = press;
`endif

    // Qualification: the pressed set must be a single player and that
    // player's own light must be lit; multi-press never wins.
    always_comb begin
        hit      = press_qual & edgeLight;
        one_hot  = (press_qual != '0) &&
                   ((press_qual & (press_qual - NUM_PLAYERS'(1))) == '0);
        qualify  = one_hot && (hit == press_qual);
        qual_idx = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (press_qual[i]) qual_idx = IDX_W'(i);
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        score_d   = score_q;
        score_inc = score_q[idx_q*SCORE_W +: SCORE_W] + SCORE_W'(1);
        case (state_q)
            IDLE: begin
                if (qualify) begin
                    state_d = WIN;
                    idx_d   = qual_idx;
                end
            end
            WIN: begin
                // Scores stop at MATCH_POINTS, so the increment cannot wrap.
                score_d[idx_q*SCORE_W +: SCORE_W] = score_inc;
                state_d = (score_inc == SCORE_W'(MATCH_POINTS)) ? MATCH_OVER : IDLE;
            end
            MATCH_OVER: state_d = MATCH_OVER;
            default:    state_d = IDLE;
        endcase
        // newMatch overrides any qualification or increment this cycle.
        if (newMatch) begin
            state_d = IDLE;
            score_d = '0;
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            score_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            score_q <= score_d;
        end
    end

    // Outputs decode purely from registered state, so reset clears them at once.
    always_comb begin
        winner      = (state_q == WIN) ? (NUM_PLAYERS'(1) << idx_q) : '0;
        gameReset   = (state_q == WIN);
        matchOver   = (state_q == MATCH_OVER);
        matchWinner = (state_q == MATCH_OVER) ? (NUM_PLAYERS'(1) << idx_q) : '0;
        score       = score_q;
    end

endmodule
